seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_pkg.sv | 14 +
 rtl/seg_hex_decoder.sv | 9 +
 rtl/seven_seg_scanner.sv | 105 ++++++++++
 tb/tb_seven_seg_scanner.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment patterns (active-low, g..a) and blank code shared by the scanner and its decoder
package seven_seg_pkg;
    typedef logic [6:0] segT;
    localparam segT SEG_BLANK = 7'h7F;
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    function automatic segT hexToSeg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction
endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: combinational hex nibble to active-low seven-segment pattern
module seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output segT        seg
);
    assign seg = hexToSeg(nibble);
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed hex display driver with frame-aligned shadow commit
// Define SEVEN_SEG_BLANK_EN to blank leading zero digits.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_COUNT  = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    enable,
    output logic                    pending,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out
);
    localparam int CW = $clog2(DIV_COUNT);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0]           divCnt;
    logic [IW-1:0]           digitIdx;
    logic                    tick;
    logic                    frameEnd;
    logic [4*NUM_DIGITS-1:0] activeData;
    logic [4*NUM_DIGITS-1:0] shadowData;
    logic [NUM_DIGITS-1:0]   activeDp;
    logic [NUM_DIGITS-1:0]   shadowDp;
    logic [NUM_DIGITS-1:0]   blankMask;
    segT                     segCode;

    assign tick     = divCnt == CW'(DIV_COUNT - 1);
    assign frameEnd = tick && digitIdx == IW'(NUM_DIGITS - 1);

    seg_hex_decoder uDecoder (
        .nibble (activeData[digitIdx*4 +: 4]),
        .seg    (segCode)
    );

`ifdef SEVEN_SEG_BLANK_EN
    always_comb begin
        logic allZero;
        allZero   = 1'b1;
        blankMask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            allZero      = allZero && activeData[4*i +: 4] == 4'h0;
            blankMask[i] = allZero && !activeDp[i];
        end
    end
`else
    assign blankMask = '0;
`endif

    // digitIdx names the slot shown at the next tick, so the first tick after reset shows digit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt   <= '0;
            digitIdx <= '0;
        end else begin
            divCnt <= tick ? '0 : divCnt + 1'b1;
            if (tick)
                digitIdx <= frameEnd ? '0 : digitIdx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            activeData <= '0;
            activeDp   <= '0;
            shadowData <= '0;
            shadowDp   <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                shadowData <= data_in;
                shadowDp   <= dp_in;
            end
            if (frameEnd) begin
                activeData <= load ? data_in : shadowData;
                activeDp   <= load ? dp_in : shadowDp;
                pending    <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_out  <= '1;
            cat_out <= SEG_BLANK;
            dp_out  <= 1'b1;
        end else if (!enable) begin
            an_out  <= '1;
            cat_out <= SEG_BLANK;
            dp_out  <= 1'b1;
        end else if (tick) begin
            an_out  <= blankMask[digitIdx] ? '1 : ~(NUM_DIGITS'(1) << digitIdx);
            cat_out <= blankMask[digitIdx] ? SEG_BLANK : segCode;
            dp_out  <= blankMask[digitIdx] || !activeDp[digitIdx];
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed checks of scan order, frame commit, enable and reset (NUM_DIGITS=4, DIV_COUNT=4)
module tb_seven_seg_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        enable = 1'b1;
    logic        pending;
    logic [6:0]  cat_out;
    logic        dp_out;
    logic [3:0]  an_out;
    int          vectors = 0;
    int          miscompares = 0;
    int          k = 0;

    seven_seg_scanner #(.NUM_DIGITS(4), .DIV_COUNT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .dp_in   (dp_in),
        .load    (load),
        .enable  (enable),
        .pending (pending),
        .cat_out (cat_out),
        .dp_out  (dp_out),
        .an_out  (an_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // k counts rising edges since reset release; all sampling happens on falling edges
    task automatic upTo(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic shown(input string tag, input logic [3:0] an, input logic [6:0] cat);
        chk({tag, "_an"}, {12'h0, an_out}, {12'h0, an});
        chk({tag, "_cat"}, {9'h0, cat_out}, {9'h0, cat});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        shown("rst_hold", 4'hF, 7'h7F);
        chk("rst_dp", {15'h0, dp_out}, 16'h1);
        chk("rst_pend", {15'h0, pending}, 16'h0);
        rst_n = 1'b1;
        upTo(3);
        shown("rst_pre_tick", 4'hF, 7'h7F);
        upTo(4);
        shown("rst_first", 4'b1110, 7'b1000000);
        data_in = 16'h1234;
        dp_in   = 4'b0000;
        load    = 1'b1;
        upTo(5);
        load = 1'b0;
        chk("scan_pend_set", {15'h0, pending}, 16'h1);
        upTo(15);
        chk("scan_pend_hold", {15'h0, pending}, 16'h1);
        upTo(16);
        chk("scan_pend_clr", {15'h0, pending}, 16'h0);
        shown("scan_old_d3", 4'b0111, 7'b1000000);
        upTo(20);
        shown("scan_d0", 4'b1110, 7'b0011001);
        upTo(23);
        shown("scan_d0_hold", 4'b1110, 7'b0011001);
        upTo(24);
        shown("scan_d1", 4'b1101, 7'b0110000);
        upTo(28);
        shown("scan_d2", 4'b1011, 7'b0100100);
        upTo(32);
        shown("scan_d3", 4'b0111, 7'b1111001);
        upTo(38);
        data_in = 16'hAAAA;
        load    = 1'b1;
        upTo(39);
        load = 1'b0;
        chk("cmt_pend_set", {15'h0, pending}, 16'h1);
        upTo(40);
        shown("cmt_old_d1", 4'b1101, 7'b0110000);
        upTo(47);
        chk("cmt_pend_hold", {15'h0, pending}, 16'h1);
        upTo(48);
        chk("cmt_pend_clr", {15'h0, pending}, 16'h0);
        shown("cmt_old_d3", 4'b0111, 7'b1111001);
        upTo(52);
        shown("cmt_new_d0", 4'b1110, 7'b0001000);
        upTo(63);
        data_in = 16'h5555;
        dp_in   = 4'b0001;
        load    = 1'b1;
        upTo(64);
        load = 1'b0;
        chk("sim_pend", {15'h0, pending}, 16'h0);
        shown("sim_old_d3", 4'b0111, 7'b0001000);
        upTo(68);
        shown("sim_d0", 4'b1110, 7'b0010010);
        chk("sim_dp", {15'h0, dp_out}, 16'h0);
        upTo(72);
        chk("sim_dp_off", {15'h0, dp_out}, 16'h1);
        upTo(79);
        data_in = 16'h0007;
        dp_in   = 4'b0000;
        load    = 1'b1;
        upTo(80);
        load = 1'b0;
        upTo(84);
        shown("blk_d0", 4'b1110, 7'b1111000);
        upTo(88);
`ifdef SEVEN_SEG_BLANK_EN
        shown("blk_d1", 4'b1111, 7'h7F);
        upTo(96);
        shown("blk_d3", 4'b1111, 7'h7F);
`else
        shown("blk_d1", 4'b1101, 7'b1000000);
        upTo(96);
        shown("blk_d3", 4'b0111, 7'b1000000);
`endif
        upTo(98);
        enable = 1'b0;
        upTo(99);
        shown("en_blank", 4'hF, 7'h7F);
        chk("en_blank_dp", {15'h0, dp_out}, 16'h1);
        upTo(100);
        data_in = 16'h89AB;
        load    = 1'b1;
        upTo(101);
        load = 1'b0;
        chk("en_pend_set", {15'h0, pending}, 16'h1);
        upTo(111);
        chk("en_pend_hold", {15'h0, pending}, 16'h1);
        upTo(112);
        chk("en_pend_clr", {15'h0, pending}, 16'h0);
        shown("en_still_blank", 4'hF, 7'h7F);
        upTo(118);
        enable = 1'b1;
        upTo(119);
        shown("en_wait_tick", 4'hF, 7'h7F);
        upTo(120);
        shown("en_d1", 4'b1101, 7'b0001000);
        upTo(124);
        shown("en_d2", 4'b1011, 7'b0010000);
        upTo(125);
        data_in = 16'h1111;
        load    = 1'b1;
        upTo(126);
        load = 1'b0;
        chk("ar_pend_pre", {15'h0, pending}, 16'h1);
        #2 rst_n = 1'b0;
        #1;
        shown("ar_async", 4'hF, 7'h7F);
        chk("ar_pend", {15'h0, pending}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        upTo(3);
        shown("ar_pre_tick", 4'hF, 7'h7F);
        upTo(4);
        shown("ar_first", 4'b1110, 7'b1000000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
